memory: RTL and testbench
=========================

# memory

Small synchronous random-access memory: 4 words of 8 bits, one write port and one read port sharing a single address bus. It is the storage block behind the memory interface that the UVM environment drives and monitors. Writes and reads are sampled on the rising clock edge. Read data is returned registered, one cycle after the request.

## Interface
Parameters:
- `ADDR_WIDTH`, default 2: address width; depth = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: word width.

Ports:
- `clk`  input  1  single clock; all sampling on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `addr`  input  ADDR_WIDTH  word address for both read and write.
- `wr_en`  input  1  write request, sampled at posedge.
- `rd_en`  input  1  read request, sampled at posedge.
- `wdata`  input  DATA_WIDTH  write data.
- `rdata`  output  DATA_WIDTH  registered read data.

## Operation
- Storage: array `mem[0 : 2**ADDR_WIDTH-1]`, each entry DATA_WIDTH bits.
- Reset (`reset` = 0):
  - Takes effect immediately, independent of `clk`.
  - Every `mem` entry is cleared to 0; `rdata` is cleared to 0.
  - While reset is held, all requests are ignored.
- Write: at a posedge with `wr_en` = 1, `mem[addr]` <= `wdata`.
- Read: at a posedge with `rd_en` = 1, `rdata` <= `mem[addr]`.
- Idle: at a posedge with `rd_en` = 0, `rdata` holds its previous value.
- Simultaneous `wr_en` and `rd_en` at the same edge:
  - Both are performed on the same `addr`.
  - The read is read-before-write: `rdata` returns the old contents and the array takes `wdata`.
- Address range: all 2**ADDR_WIDTH addresses are valid. No out-of-range case exists, and there is no wrap logic.
- No error or ready signalling. Every request completes at the edge that samples it.

## Timing
- Write latency: data is stored at the sampling edge. A read of the same address at the next edge returns the new data.
- Read latency: 1 cycle. `rdata` changes just after the posedge that samples `rd_en` and is stable for the whole following cycle.
- Bench conventions:
  - Drivers update inputs 1 time unit after posedge.
  - Monitors sample `rdata` 1 time unit before the next posedge.
  - Read data for a request driven in cycle N is therefore observed by the monitor at the end of cycle N+1.
- Back-to-back reads to different addresses are supported every cycle at full throughput.
- Reset deassertion:
  - Takes effect asynchronously.
  - The first posedge after `reset` rises may carry a request, which is honoured normally.
- Reset asserted mid-operation:
  - An in-flight write at a coinciding edge is lost.
  - `rdata` goes to 0 immediately.

## Test plan
- Reset: assert `reset` = 0 with random prior contents, then release. Reading addresses 0..3 must return 0x00 each, and `rdata` must be 0x00 during reset.
- Write/read all locations: write 0x11, 0x22, 0x33, 0x44 to addresses 0..3, then read 0..3 back-to-back. `rdata` must be 0x11, 0x22, 0x33, 0x44 on consecutive cycles, each one cycle after its request.
- Read-before-write: `mem[2]` = 0x5A. At one edge drive `wr_en` = `rd_en` = 1, `addr` = 2, `wdata` = 0xC3. `rdata` must be 0x5A, and a read of address 2 on the next cycle must return 0xC3.
- Hold: after reading 0x44 from address 3, keep `rd_en` = 0 for 5 cycles while writing 0xFF to address 3. `rdata` must stay 0x44.
- Overwrite: write 0xAA then 0x55 to address 1 on consecutive cycles, then read address 1. Result must be 0x55, and addresses 0, 2, 3 must be unchanged.
- Async reset mid-stream: assert `reset` = 0 between clock edges during a read burst. `rdata` must become 0x00 before the next posedge, and a later read of any address must return 0x00.

Source files
------------

// File: rtl/memory_if.sv
// Request/response bundle between a memory client and the memory block.
// Requests are sampled on the rising clock edge; rdata is registered inside the memory.
interface memory_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output addr,
        output wr_en,
        output rd_en,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  rd_en,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/memory.sv
// Small synchronous RAM: one write and one read port sharing an address.
// Read data is registered with one cycle of latency; a simultaneous read and write returns the old word.
module memory #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    memory_if.slave   bus
);
    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read samples the array before the same-edge write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (bus.rd_en) begin
                rdata_q <= mem[bus.addr];
            end
            if (bus.wr_en) begin
                mem[bus.addr] <= bus.wdata;
            end
        end
    end

    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: reads push expected words from a reference array,
// and the word is popped and compared one time unit before the edge ending the next cycle.
module tb_memory;
    typedef struct {
        logic [7:0] data;
        int         cyc;
        string      name;
    } exp_t;

    typedef struct {
        logic       we;
        logic       re;
        logic [1:0] a;
        logic [7:0] d;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    memory #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] mdl [4];
    exp_t       sb [$];

    // Drive one request 1 time unit after the edge; reads enqueue the reference word.
    task automatic drive(input logic we, input logic re, input logic [1:0] a,
                         input logic [7:0] d, input string nm);
        @(posedge clk);
        #1;
        bus.wr_en = we;
        bus.rd_en = re;
        bus.addr  = a;
        bus.wdata = d;
        cyc++;
        if (re && reset) sb.push_back('{mdl[a], cyc, nm});
        if (we && reset) mdl[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] v;
        op_t ops[5] = '{'{1'b0, 1'b1, 2'd1, 8'h00}, '{1'b0, 1'b1, 2'd2, 8'h00},
                        '{1'b0, 1'b1, 2'd3, 8'h00}, '{1'b0, 1'b0, 2'd0, 8'h00},
                        '{1'b0, 1'b0, 2'd0, 8'h00}};
        #1;
        checks++;
        if (bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial: rdata=%02h expected=00", bus.rdata);
        end
        #20;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom_range(1, 255));
            drive(1'b1, 1'b0, 2'(i), v, "rst_fill");
        end
        drive(1'b0, 1'b1, 2'd2, 8'h00, "rst_prior");
        #8;
        drive(1'b0, 1'b0, 2'd0, 8'h00, "idle");
        #3;
        reset = 1'b0;
        clear_model();
        #1;
        checks++;
        if (bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_assert: rdata=%02h expected=00", bus.rdata);
        end
        // Requests during reset must be ignored.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 2'(k), 8'hEE, "rst_ignored");
            #8;
            checks++;
            if (bus.rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_held: rdata=%02h expected=00", bus.rdata);
            end
        end
        // Release and issue a read on the very first edge afterwards.
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        bus.addr  = 2'd0;
        cyc++;
        sb.push_back('{mdl[0], cyc, "rst_read"});
        for (int k = 0; k < 5; k++) begin
            drive(ops[k].we, ops[k].re, ops[k].a, ops[k].d, "rst_read");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                end
            end
        end
    endtask

    task automatic test_write_read_all();
        exp_t e;
        op_t ops[10] = '{'{1'b1, 1'b0, 2'd0, 8'h11}, '{1'b1, 1'b0, 2'd1, 8'h22},
                         '{1'b1, 1'b0, 2'd2, 8'h33}, '{1'b1, 1'b0, 2'd3, 8'h44},
                         '{1'b0, 1'b1, 2'd0, 8'h00}, '{1'b0, 1'b1, 2'd1, 8'h00},
                         '{1'b0, 1'b1, 2'd2, 8'h00}, '{1'b0, 1'b1, 2'd3, 8'h00},
                         '{1'b0, 1'b0, 2'd0, 8'h00}, '{1'b0, 1'b0, 2'd0, 8'h00}};
        for (int k = 0; k < 10; k++) begin
            drive(ops[k].we, ops[k].re, ops[k].a, ops[k].d, "write_read_all");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                end
            end
        end
    endtask

    task automatic test_read_before_write();
        exp_t e;
        op_t ops[5] = '{'{1'b1, 1'b0, 2'd2, 8'h5A}, '{1'b1, 1'b1, 2'd2, 8'hC3},
                        '{1'b0, 1'b1, 2'd2, 8'h00}, '{1'b0, 1'b0, 2'd0, 8'h00},
                        '{1'b0, 1'b0, 2'd0, 8'h00}};
        for (int k = 0; k < 5; k++) begin
            drive(ops[k].we, ops[k].re, ops[k].a, ops[k].d, "read_before_write");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [7:0] held = 8'h00;
        drive(1'b0, 1'b1, 2'd3, 8'h00, "hold_read");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 2'd3, 8'hFF, "hold_idle");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                held = e.data;
                checks++;
                if (bus.rdata !== 8'h44) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=44", e.name, bus.rdata);
                end
            end else begin
                checks++;
                if (bus.rdata !== held) begin
                    errors++;
                    $display("FAIL hold_cycle%0d: rdata=%02h expected=%02h", k, bus.rdata, held);
                end
            end
        end
    endtask

    task automatic test_overwrite();
        exp_t e;
        op_t ops[7] = '{'{1'b1, 1'b0, 2'd1, 8'hAA}, '{1'b1, 1'b0, 2'd1, 8'h55},
                        '{1'b0, 1'b1, 2'd1, 8'h00}, '{1'b0, 1'b1, 2'd0, 8'h00},
                        '{1'b0, 1'b1, 2'd2, 8'h00}, '{1'b0, 1'b1, 2'd3, 8'h00},
                        '{1'b0, 1'b0, 2'd0, 8'h00}};
        for (int k = 0; k < 7; k++) begin
            drive(ops[k].we, ops[k].re, ops[k].a, ops[k].d, "overwrite");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        op_t ops[5] = '{'{1'b0, 1'b1, 2'd0, 8'h00}, '{1'b0, 1'b1, 2'd1, 8'h00},
                        '{1'b0, 1'b1, 2'd2, 8'h00}, '{1'b0, 1'b1, 2'd3, 8'h00},
                        '{1'b0, 1'b0, 2'd0, 8'h00}};
        // Burst of reads; reset lands between edges while address 2 is in flight.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 2'(k), 8'h00, "burst");
            if (k == 2) begin
                #3;
                reset = 1'b0;
                clear_model();
                #1;
                checks++;
                if (bus.rdata !== 8'h00) begin
                    errors++;
                    $display("FAIL async_reset_rdata: rdata=%02h expected=00", bus.rdata);
                end
                #4;
            end else begin
                #8;
                if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.rdata !== e.data) begin
                        errors++;
                        $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 2'd0, 8'h00, "idle");
        #4;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(ops[k].we, ops[k].re, ops[k].a, ops[k].d, "post_reset_read");
            #8;
            if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%02h expected=%02h", e.name, bus.rdata, e.data);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 8'h00;
        clear_model();
        test_reset();
        test_write_read_all();
        test_read_before_write();
        test_hold();
        test_overwrite();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
